// File: rtl/minterm_scanner.sv
// Drives x,y,z,w through all 16 minterms of an external 4-input function and captures s into a mask plus ones count.
// Optional compare-against-expected logic is enabled by defining MINTERM_SCANNER_CHECK_EN.
module minterm_scanner #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        s,
`ifdef MINTERM_SCANNER_CHECK_EN
    input  logic [15:0] expected,
    output logic        mismatch,
    output logic [3:0]  first_bad,
`endif
    output logic        x,
    output logic        y,
    output logic        z,
    output logic        w,
    output logic        busy,
    output logic        done,
    output logic [15:0] mask,
    output logic        mask_valid,
    output logic [4:0]  ones_count
);

    localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] mask_q, mask_d;
    logic [4:0]  ones_q, ones_d;
    logic        valid_q, valid_d;
    logic        s_one;
    logic        go_scan;
    logic        enter_done;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        ones_d     = ones_q;
        valid_d    = valid_q;
        go_scan    = 1'b0;
        enter_done = 1'b0;
        // Anything other than a clean 1 (including X/Z) counts as 0.
        s_one = 1'b0;
        if (s == 1'b1) begin
            s_one = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    go_scan = 1'b1;
                    state_d = S_DRIVE;
                    idx_d   = '0;
                    cnt_d   = RELOAD;
                    mask_d  = '0;
                    ones_d  = '0;
                    valid_d = 1'b0;
                end
            end
            S_DRIVE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    mask_d[idx_q] = s_one;
                    ones_d        = ones_q + {4'b0000, s_one};
                    if (idx_q == 4'hF) begin
                        state_d    = S_DONE;
                        valid_d    = 1'b1;
                        enter_done = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        cnt_d = RELOAD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            ones_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            ones_q  <= ones_d;
            valid_q <= valid_d;
        end
    end

`ifdef MINTERM_SCANNER_CHECK_EN
    logic mismatch_q, mismatch_d;

    always_comb begin
        mismatch_d = mismatch_q;
        if (go_scan) begin
            mismatch_d = 1'b0;
        end
        if (enter_done) begin
            mismatch_d = (mask_d != expected);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    // Scan downward so the lowest differing index is the one left standing.
    always_comb begin
        first_bad = '0;
        for (int unsigned i = 16; i > 0; i--) begin
            if (mask_q[i-1] != expected[i-1]) begin
                first_bad = 4'(i - 1);
            end
        end
    end

    assign mismatch = mismatch_q;
`else
    logic unused_flags;
    assign unused_flags = go_scan ^ enter_done;
`endif

    assign {x, y, z, w} = idx_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign mask         = mask_q;
    assign mask_valid   = valid_q;
    assign ones_count   = ones_q;

endmodule
